// File: rtl/pfiform_pkg.sv
// Shared constants and FSM state type for the pfiform job sequencer.
package pfiform_pkg;
   localparam int SYM_W = 6;
   localparam int LANES = 32;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;
endpackage

// File: rtl/pfiform_chunk_calc.sv
// Chunk size for one join or pop: min(size+1, rem)-1, reported as 0 when rem is 0.
module pfiform_chunk_calc #(
   parameter int CNT_W = 16,
   parameter int SZ_W  = 5
) (
   input  logic [SZ_W-1:0]  size,
   input  logic [CNT_W-1:0] rem,
   output logic [SZ_W-1:0]  amt
);

   always_comb begin
      if (rem > CNT_W'(size)) begin
         amt = size;
      end else if (rem == '0) begin
         amt = '0;
      end else begin
         amt = SZ_W'(rem - CNT_W'(1));
      end
   end

endmodule

// File: rtl/pfiform_seq.sv
// Job sequencer driving the join and pop sides of a symbol FIFO in size-limited chunks.
module pfiform_seq #(
   parameter  int SYM_W = pfiform_pkg::SYM_W,
   parameter  int LANES = pfiform_pkg::LANES,
   parameter  int CNT_W = pfiform_pkg::CNT_W,
   localparam int SZ_W  = $clog2(LANES)
) (
   input  logic             i_core_clk,
   input  logic             i_rx_rst,
   input  logic             i_job_start,
   input  logic [CNT_W-1:0] i_job_len,
   input  logic [SZ_W-1:0]  i_join_sz,
   input  logic [SZ_W-1:0]  i_pop_sz,
   input  logic             i_src_valid,
   input  logic             i_sink_ready,
   output logic             JoinEnable,
   input  logic             JoinPermit,
   output logic [SZ_W-1:0]  JoinAmout,
   output logic             PopPermit,
   input  logic             PopEnable,
   output logic [SZ_W-1:0]  PopAmout,
   output logic             o_job_busy,
   output logic             o_job_done,
   output logic             o_err,
   output logic [CNT_W-1:0] o_join_rem,
   output logic [CNT_W-1:0] o_pop_rem
);

   import pfiform_pkg::*;

   state_e           state, state_nxt;
   logic [SZ_W-1:0]  join_sz, join_sz_nxt;
   logic [SZ_W-1:0]  pop_sz, pop_sz_nxt;
   logic [CNT_W-1:0] join_rem, join_rem_nxt;
   logic [CNT_W-1:0] pop_rem, pop_rem_nxt;
   logic [SZ_W-1:0]  join_amt, pop_amt;
   logic             join_fire, pop_ok, pop_bad;

   pfiform_chunk_calc #(.CNT_W(CNT_W), .SZ_W(SZ_W)) u_join_calc (
      .size (join_sz),
      .rem  (join_rem),
      .amt  (join_amt)
   );

   pfiform_chunk_calc #(.CNT_W(CNT_W), .SZ_W(SZ_W)) u_pop_calc (
      .size (pop_sz),
      .rem  (pop_rem),
      .amt  (pop_amt)
   );

   assign JoinEnable = (state == ST_RUN) && (join_rem != '0) && i_src_valid;
   assign JoinAmout  = join_amt;
   assign PopPermit  = ((state == ST_RUN) || (state == ST_DRAIN)) && (pop_rem != '0) && i_sink_ready;
   assign PopAmout   = pop_amt;
   assign join_fire  = JoinEnable && JoinPermit;
   // A pop with nothing owed is a FIFO-side protocol error; it never touches the counter.
   assign pop_bad    = PopEnable && ((state == ST_IDLE) || (pop_rem == '0));
   assign pop_ok     = PopEnable && !pop_bad;
   assign o_job_busy = (state != ST_IDLE);
   assign o_job_done = (state == ST_DONE);
   assign o_join_rem = join_rem;
   assign o_pop_rem  = pop_rem;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_nxt    = state;
      join_sz_nxt  = join_sz;
      pop_sz_nxt   = pop_sz;
      join_rem_nxt = join_rem;
      pop_rem_nxt  = pop_rem;

      if (join_fire) join_rem_nxt = join_rem - CNT_W'(join_amt) - CNT_W'(1);
      if (pop_ok)    pop_rem_nxt  = pop_rem - CNT_W'(pop_amt) - CNT_W'(1);

      case (state)
         ST_IDLE: begin
            if (i_job_start && (i_job_len != '0)) begin
               join_sz_nxt  = i_join_sz;
               pop_sz_nxt   = i_pop_sz;
               join_rem_nxt = i_job_len;
               pop_rem_nxt  = i_job_len;
               state_nxt    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (join_rem_nxt == '0) state_nxt = (pop_rem_nxt == '0) ? ST_DONE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pop_rem_nxt == '0) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
      if (i_rx_rst) begin
         state    <= ST_IDLE;
         join_sz  <= '0;
         pop_sz   <= '0;
         join_rem <= '0;
         pop_rem  <= '0;
         o_err    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values, independent of order.
         state    <= state_nxt;
         join_sz  <= join_sz_nxt;
         pop_sz   <= pop_sz_nxt;
         join_rem <= join_rem_nxt;
         pop_rem  <= pop_rem_nxt;
         o_err    <= o_err | pop_bad;
      end
   end

endmodule

// File: tb/tb_pfiform_seq.sv
// Directed bench for pfiform_seq: chunk sequences, stalls, overlap, ignored starts, errors, reset.
module tb_pfiform_seq;

   logic        tb_sclk = 1'b0;
   logic        rst = 1'b1;
   logic        job_start = 1'b0;
   logic [15:0] job_len = '0;
   logic [4:0]  join_sz_in = '0;
   logic [4:0]  pop_sz_in = '0;
   logic        src_valid = 1'b0;
   logic        sink_ready = 1'b0;
   logic        join_permit = 1'b0;
   logic        pop_en = 1'b0;

   logic        join_en, pop_permit, job_busy, job_done, err;
   logic [4:0]  join_amt, pop_amt;
   logic [15:0] join_rem, pop_rem;

   int total = 0;
   int bad = 0;

   logic [4:0] join_log[$];
   logic [4:0] pop_log[$];
   int         done_cnt;
   int         done_pop_idx;

   always #5 tb_sclk = ~tb_sclk;

   pfiform_seq dut (
      .i_core_clk   (tb_sclk),
      .i_rx_rst     (rst),
      .i_job_start  (job_start),
      .i_job_len    (job_len),
      .i_join_sz    (join_sz_in),
      .i_pop_sz     (pop_sz_in),
      .i_src_valid  (src_valid),
      .i_sink_ready (sink_ready),
      .JoinEnable   (join_en),
      .JoinPermit   (join_permit),
      .JoinAmout    (join_amt),
      .PopPermit    (pop_permit),
      .PopEnable    (pop_en),
      .PopAmout     (pop_amt),
      .o_job_busy   (job_busy),
      .o_job_done   (job_done),
      .o_err        (err),
      .o_join_rem   (join_rem),
      .o_pop_rem    (pop_rem)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_job(input logic [15:0] len, input logic [4:0] jsz, input logic [4:0] psz);
      @(negedge tb_sclk);
      job_start  = 1'b1;
      job_len    = len;
      join_sz_in = jsz;
      pop_sz_in  = psz;
      @(negedge tb_sclk);
      job_start  = 1'b0;
   endtask

   // Emulates a FIFO that pops whenever permitted; logs chunk sizes until the job returns to idle.
   task automatic run_job(input int max_cyc);
      join_log.delete();
      pop_log.delete();
      done_cnt     = 0;
      done_pop_idx = -1;
      for (int c = 0; c < max_cyc; c++) begin
         if (job_done) begin
            done_cnt++;
            done_pop_idx = pop_log.size();
         end
         if (!job_busy) break;
         if (join_en && join_permit) join_log.push_back(join_amt);
         pop_en = pop_permit;
         if (pop_permit) pop_log.push_back(pop_amt);
         @(negedge tb_sclk);
      end
      pop_en = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge tb_sclk);
      total++; if (job_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", job_busy); end
      total++; if (join_rem !== 16'd0) begin bad++; $display("FAIL reset_join_rem: got %0d want 0", join_rem); end
      total++; if (err !== 1'b0 || job_done !== 1'b0) begin bad++; $display("FAIL reset_err_done: got %b%b want 00", err, job_done); end
      rst = 1'b0;
   endtask

   task automatic test_len64();
      logic [4:0] exp_j[7] = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd3};
      logic [4:0] exp_p[4] = '{5'd18, 5'd18, 5'd18, 5'd6};
      src_valid = 1'b1; join_permit = 1'b1; sink_ready = 1'b1;
      start_job(16'd64, 5'd9, 5'd18);
      run_job(40);
      total++; if (join_log.size() != 7) begin bad++; $display("FAIL l64_join_count: got %0d want 7", join_log.size()); end
      for (int i = 0; i < 7 && i < join_log.size(); i++) begin
         total++; if (join_log[i] !== exp_j[i]) begin bad++; $display("FAIL l64_join_amt[%0d]: got %0d want %0d", i, join_log[i], exp_j[i]); end
      end
      total++; if (pop_log.size() != 4) begin bad++; $display("FAIL l64_pop_count: got %0d want 4", pop_log.size()); end
      for (int i = 0; i < 4 && i < pop_log.size(); i++) begin
         total++; if (pop_log[i] !== exp_p[i]) begin bad++; $display("FAIL l64_pop_amt[%0d]: got %0d want %0d", i, pop_log[i], exp_p[i]); end
      end
      total++; if (done_cnt != 1 || done_pop_idx != 4) begin bad++; $display("FAIL l64_done: got %0d pulses after %0d pops want 1 after 4", done_cnt, done_pop_idx); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL l64_err: got %b want 0", err); end
   endtask

   task automatic test_len32();
      start_job(16'd32, 5'd31, 5'd31);
      run_job(10);
      total++; if (join_log.size() != 1 || join_log[0] !== 5'd31) begin bad++; $display("FAIL l32_join: got %0d chunks want one of 31", join_log.size()); end
      total++; if (pop_log.size() != 1 || pop_log[0] !== 5'd31) begin bad++; $display("FAIL l32_pop: got %0d chunks want one of 31", pop_log.size()); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL l32_done: got %0d pulses want 1", done_cnt); end
   endtask

   task automatic test_join_stall();
      sink_ready = 1'b0;
      start_job(16'd43, 5'd9, 5'd9);
      repeat (4) @(negedge tb_sclk);
      join_permit = 1'b0;
      total++; if (join_rem !== 16'd3) begin bad++; $display("FAIL stall_setup_rem: got %0d want 3", join_rem); end
      for (int i = 0; i < 5; i++) begin
         @(negedge tb_sclk);
         total++; if (join_en !== 1'b1) begin bad++; $display("FAIL stall_enable[%0d]: got %b want 1", i, join_en); end
         total++; if (join_amt !== 5'd2) begin bad++; $display("FAIL stall_amt[%0d]: got %0d want 2", i, join_amt); end
         total++; if (join_rem !== 16'd3) begin bad++; $display("FAIL stall_rem[%0d]: got %0d want 3", i, join_rem); end
      end
      join_permit = 1'b1; sink_ready = 1'b1;
      run_job(30);
      total++; if (done_cnt != 1 || pop_log.size() != 5) begin bad++; $display("FAIL stall_finish: got %0d done %0d pops want 1 done 5 pops", done_cnt, pop_log.size()); end
   endtask

   task automatic test_simultaneous();
      start_job(16'd40, 5'd9, 5'd9);
      pop_en = 1'b1;
      @(negedge tb_sclk);
      pop_en = 1'b0; join_permit = 1'b0;
      total++; if (join_rem !== 16'd30) begin bad++; $display("FAIL sim_join_rem: got %0d want 30", join_rem); end
      total++; if (pop_rem !== 16'd30) begin bad++; $display("FAIL sim_pop_rem: got %0d want 30", pop_rem); end
      join_permit = 1'b1;
      run_job(30);
      total++; if (done_cnt != 1) begin bad++; $display("FAIL sim_done: got %0d pulses want 1", done_cnt); end
   endtask

   task automatic test_ignore_and_err();
      join_permit = 1'b0; sink_ready = 1'b0;
      start_job(16'd20, 5'd4, 5'd4);
      job_start = 1'b1; job_len = 16'd100; join_sz_in = 5'd31; pop_sz_in = 5'd31;
      @(negedge tb_sclk);
      job_start = 1'b0;
      total++; if (join_rem !== 16'd20 || pop_rem !== 16'd20) begin bad++; $display("FAIL busy_start_rem: got %0d/%0d want 20/20", join_rem, pop_rem); end
      total++; if (join_amt !== 5'd4) begin bad++; $display("FAIL busy_start_amt: got %0d want 4", join_amt); end
      join_permit = 1'b1; sink_ready = 1'b1;
      run_job(30);
      total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_start_done: got %0d pulses want 1", done_cnt); end
      job_start = 1'b1; job_len = 16'd0;
      @(negedge tb_sclk);
      job_start = 1'b0;
      @(negedge tb_sclk);
      total++; if (job_busy !== 1'b0 || join_en !== 1'b0) begin bad++; $display("FAIL zero_len_start: got busy=%b en=%b want 0 0", job_busy, join_en); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_before: got %b want 0", err); end
      pop_en = 1'b1;
      @(negedge tb_sclk);
      pop_en = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL idle_pop_err: got %b want 1", err); end
      @(negedge tb_sclk);
      total++; if (err !== 1'b1 || pop_rem !== 16'd0) begin bad++; $display("FAIL err_sticky: got err=%b pop_rem=%0d want 1 0", err, pop_rem); end
   endtask

   task automatic test_mid_reset();
      join_permit = 1'b0; sink_ready = 1'b1; src_valid = 1'b1;
      start_job(16'd64, 5'd9, 5'd18);
      @(negedge tb_sclk);
      rst = 1'b1;
      #1;
      total++; if (join_en !== 1'b0 || pop_permit !== 1'b0 || job_busy !== 1'b0) begin bad++; $display("FAIL rst_ctrl: got en=%b permit=%b busy=%b want 000", join_en, pop_permit, job_busy); end
      total++; if (join_amt !== 5'd0 || pop_amt !== 5'd0) begin bad++; $display("FAIL rst_amt: got %0d/%0d want 0/0", join_amt, pop_amt); end
      total++; if (join_rem !== 16'd0 || pop_rem !== 16'd0) begin bad++; $display("FAIL rst_rem: got %0d/%0d want 0/0", join_rem, pop_rem); end
      total++; if (err !== 1'b0 || job_done !== 1'b0) begin bad++; $display("FAIL rst_err_done: got %b%b want 00", err, job_done); end
      @(negedge tb_sclk);
      rst = 1'b0;
      @(negedge tb_sclk);
      total++; if (job_busy !== 1'b0 || join_en !== 1'b0) begin bad++; $display("FAIL rst_release_idle: got busy=%b en=%b want 0 0", job_busy, join_en); end
   endtask

   initial begin
      test_reset();
      test_len64();
      test_len32();
      test_join_stall();
      test_simultaneous();
      test_ignore_and_err();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
